// File: rtl/onchip_pixel_writer_pkg.sv
// Shared types and constants for the on-chip pixel writer and its word packer.
package onchip_pixel_writer_pkg;

  localparam int DEF_ADDR_W    = 15;
  localparam int DEF_MAX_WORDS = 25000;
  localparam int LANES         = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    CAPTURE,
    FLUSH,
    DONE
  } pw_state_t;

  // Byte enables indexed by the last populated lane of a word.
  localparam logic [3:0] LANE_BE [LANES] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

endpackage

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: gathers 8-bit pixels little-endian into a 32-bit word.
// The word output is combinational and already includes the byte being pushed,
// so the owner can register a complete or partial word on the accepting edge.
module pixel_word_packer
  import onchip_pixel_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [1:0]  lane,
  output logic [31:0] word,
  output logic        word_full,
  output logic        partial_valid
);

  logic [1:0] lane_reg;

  // Lane counter: wraps after lane 3 so every word starts at lane 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_reg <= '0;
    end else if (clear) begin
      lane_reg <= '0;
    end else if (push) begin
      lane_reg <= lane_reg + 2'd1;
    end
  end

  assign lane          = lane_reg;
  assign word_full     = (lane_reg == 2'd3);
  assign partial_valid = (lane_reg != 2'd0);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] byte_reg;
      logic       hit;

      assign hit = push && (lane_reg == 2'(gi));

      // Lane byte storage; cleared after each emitted word so unused lanes read as zero.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          byte_reg <= '0;
        end else if (clear || (push && word_full)) begin
          byte_reg <= '0;
        end else if (hit) begin
          byte_reg <= data;
        end
      end

      assign word[8*gi +: 8] = hit ? data : byte_reg;
    end
  endgenerate

endmodule

// File: rtl/onchip_pixel_writer.sv
// onchip_pixel_writer: captures one pixel packet and writes it as packed
// 32-bit words into the on-chip frame RAM through a simple Avalon write port.
// Optional running checksum of written words: define ONCHIP_PIXEL_WRITER_CSUM_EN.
module onchip_pixel_writer
  import onchip_pixel_writer_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              framing_err,
`ifdef ONCHIP_PIXEL_WRITER_CSUM_EN
  output logic [31:0]       csum,
`endif
  output logic [ADDR_W-1:0] word_count
);

  localparam int CAP_W = ADDR_W + 1;

  pw_state_t state_reg, state_next;

  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] word_count_reg;   // doubles as the write word index
  logic [ADDR_W-1:0] mem_address_reg;
  logic [3:0]        mem_byteenable_reg;
  logic [31:0]       mem_writedata_reg;
  logic              mem_write_reg;
  logic              clken_reg;
  logic              overflow_reg;
  logic              framing_err_reg;

  logic        beat;
  logic        start_ok;
  logic        full;
  logic [CAP_W-1:0] fill;

  logic        push;
  logic        pk_clear;
  logic        wr_en;
  logic [1:0]  wr_last_lane;
  logic        set_overflow;
  logic        set_ferr;

  logic [1:0]  pk_lane;
  logic [31:0] pk_word;
  logic        pk_word_full;
  logic        pk_partial;

  pixel_word_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (pk_clear),
    .push          (push),
    .data          (in_data),
    .lane          (pk_lane),
    .word          (pk_word),
    .word_full     (pk_word_full),
    .partial_valid (pk_partial)
  );

  assign beat     = in_valid && in_ready;
  assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));
  // Capacity is reached once base + written words hits the RAM depth; a base
  // at or past the depth means no room at all.
  assign fill     = {1'b0, base_reg} + {1'b0, word_count_reg};
  assign full     = (fill >= CAP_W'(MAX_WORDS));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (beat && in_sop) begin
          if (!in_eop)   state_next = CAPTURE;
          else if (full) state_next = DONE;
          else           state_next = FLUSH;
        end
      end
      CAPTURE: begin
        if (beat) begin
          if (in_sop)                      state_next = pk_partial ? FLUSH : DONE;
          else if (in_eop)                 state_next = (full || pk_word_full) ? DONE : FLUSH;
        end
      end
      FLUSH:   state_next = DONE;
      DONE: begin
        if (start) state_next = WAIT_SOP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-state outputs and datapath actions.
  always_comb begin
    in_ready     = (state_reg == WAIT_SOP) || (state_reg == CAPTURE);
    busy         = in_ready || (state_reg == FLUSH);
    done         = (state_reg == DONE);
    push         = 1'b0;
    pk_clear     = 1'b0;
    wr_en        = 1'b0;
    wr_last_lane = 2'd3;
    set_overflow = 1'b0;
    set_ferr     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        pk_clear = start;
      end
      WAIT_SOP: begin
        // Beats before the sop are accepted and discarded.
        if (beat && in_sop) begin
          if (full) begin
            set_overflow = 1'b1;
          end else begin
            push = 1'b1;
            if (in_eop) begin
              wr_en        = 1'b1;
              wr_last_lane = 2'd0;
              pk_clear     = 1'b1;
            end
          end
        end
      end
      CAPTURE: begin
        if (beat) begin
          if (in_sop) begin
            // Stray sop: drop that beat and flush whatever is pending.
            set_ferr = 1'b1;
            pk_clear = 1'b1;
            if (pk_partial) begin
              wr_en        = 1'b1;
              wr_last_lane = pk_lane - 2'd1;
            end
          end else if (full) begin
            set_overflow = 1'b1;
          end else begin
            push = 1'b1;
            if (pk_word_full) begin
              wr_en = 1'b1;
            end else if (in_eop) begin
              wr_en        = 1'b1;
              wr_last_lane = pk_lane;
              pk_clear     = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Write port, counters and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_reg           <= '0;
      word_count_reg     <= '0;
      mem_address_reg    <= '0;
      mem_byteenable_reg <= '0;
      mem_writedata_reg  <= '0;
      mem_write_reg      <= 1'b0;
      clken_reg          <= 1'b0;
      overflow_reg       <= 1'b0;
      framing_err_reg    <= 1'b0;
    end else begin
      clken_reg     <= 1'b1;
      mem_write_reg <= wr_en;
      if (wr_en) begin
        mem_address_reg    <= base_reg + word_count_reg;
        mem_byteenable_reg <= LANE_BE[wr_last_lane];
        mem_writedata_reg  <= pk_word;
        word_count_reg     <= word_count_reg + 1'b1;
      end
      if (set_overflow) overflow_reg    <= 1'b1;
      if (set_ferr)     framing_err_reg <= 1'b1;
      if (start_ok) begin
        base_reg        <= base_addr;
        word_count_reg  <= '0;
        overflow_reg    <= 1'b0;
        framing_err_reg <= 1'b0;
      end
    end
  end

`ifdef ONCHIP_PIXEL_WRITER_CSUM_EN
  logic [31:0] csum_reg;

  // Running sum of every word presented to the RAM, one cycle behind the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_reg <= '0;
    end else if (start_ok) begin
      csum_reg <= '0;
    end else if (mem_write_reg) begin
      csum_reg <= csum_reg + mem_writedata_reg;
    end
  end

  assign csum = csum_reg;
`endif

  assign mem_address    = mem_address_reg;
  assign mem_byteenable = mem_byteenable_reg;
  assign mem_writedata  = mem_writedata_reg;
  assign mem_write      = mem_write_reg;
  assign mem_chipselect = mem_write_reg;
  assign mem_clken      = clken_reg;
  assign overflow       = overflow_reg;
  assign framing_err    = framing_err_reg;
  assign word_count     = word_count_reg;

endmodule

// File: tb/tb_onchip_pixel_writer.sv
// Directed bench for onchip_pixel_writer: one task per scenario, inline checks.
module tb_onchip_pixel_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        framing_err;
  logic [14:0] word_count;
`ifdef ONCHIP_PIXEL_WRITER_CSUM_EN
  logic [31:0] csum;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [14:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_be   [$];

  onchip_pixel_writer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .framing_err    (framing_err),
`ifdef ONCHIP_PIXEL_WRITER_CSUM_EN
    .csum           (csum),
`endif
    .word_count     (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write, one line each.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      log_addr.push_back(mem_address);
      log_data.push_back(mem_writedata);
      log_be.push_back(mem_byteenable);
      $display("write addr=0x%04h data=0x%08h be=%b", mem_address, mem_writedata, mem_byteenable);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e);
    in_data = d; in_valid = 1'b1; in_sop = s; in_eop = e;
    tick();
    in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic do_start(input logic [14:0] b);
    log_addr.delete(); log_data.delete(); log_be.delete();
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0;
    in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    tick(2);
    compared++;
    if ({mem_write, mem_chipselect, mem_clken, busy, done, overflow, framing_err, in_ready} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {mem_write, mem_chipselect, mem_clken, busy, done, overflow, framing_err, in_ready});
    end
    compared++;
    if ({word_count, mem_address, mem_byteenable, mem_writedata} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: count=%h addr=%h be=%b data=%h expected all zero",
               word_count, mem_address, mem_byteenable, mem_writedata);
    end
    reset = 1'b0;
    tick(2);
    compared++;
    if ({mem_clken, in_ready, busy} !== 3'b100) begin
      mismatched++;
      $display("FAIL idle_after_reset: clken/ready/busy got %b expected 100", {mem_clken, in_ready, busy});
    end
  endtask

  task automatic test_full_words();
    do_start(15'h0000);
    for (int i = 0; i < 8; i++) beat(8'(i + 1), i == 0, i == 7);
    wait_done();
    tick(3);
    compared++;
    if (done !== 1'b1 || word_count !== 15'd2) begin
      mismatched++;
      $display("FAIL full_words_status: done=%b count=%0d expected done=1 count=2", done, word_count);
    end
    compared++;
    if (log_addr.size() !== 2) begin
      mismatched++;
      $display("FAIL full_words_nwrites: got %0d expected 2", log_addr.size());
    end else if ({log_addr[0], log_data[0], log_be[0], log_addr[1], log_data[1], log_be[1]} !==
                 {15'h0000, 32'h04030201, 4'hF, 15'h0001, 32'h08070605, 4'hF}) begin
      mismatched++;
      $display("FAIL full_words_data: got @%h %h %b, @%h %h %b expected @0000 04030201 1111, @0001 08070605 1111",
               log_addr[0], log_data[0], log_be[0], log_addr[1], log_data[1], log_be[1]);
    end
`ifdef ONCHIP_PIXEL_WRITER_CSUM_EN
    compared++;
    if (csum !== 32'h0C0A0806) begin
      mismatched++;
      $display("FAIL csum: got %h expected 0c0a0806", csum);
    end
`endif
  endtask

  task automatic test_partial();
    do_start(15'h0010);
    for (int i = 0; i < 6; i++) beat(8'(i + 1), i == 0, i == 5);
    wait_done();
    tick(3);
    compared++;
    if (log_addr.size() !== 2) begin
      mismatched++;
      $display("FAIL partial_nwrites: got %0d expected 2", log_addr.size());
    end else if ({log_addr[0], log_be[0], log_addr[1], log_data[1], log_be[1]} !==
                 {15'h0010, 4'hF, 15'h0011, 32'h00000605, 4'b0011}) begin
      mismatched++;
      $display("FAIL partial_data: got @%h be=%b, @%h %h be=%b expected @0010 be=1111, @0011 00000605 be=0011",
               log_addr[0], log_be[0], log_addr[1], log_data[1], log_be[1]);
    end
    compared++;
    if (done !== 1'b1 || word_count !== 15'd2) begin
      mismatched++;
      $display("FAIL partial_status: done=%b count=%0d expected done=1 count=2", done, word_count);
    end
  endtask

  task automatic test_junk();
    do_start(15'h0020);
    beat(8'hAA, 1'b0, 1'b0);
    beat(8'hBB, 1'b0, 1'b0);
    beat(8'hCC, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) beat(8'hB0 + 8'(i), i == 0, i == 3);
    wait_done();
    tick(3);
    compared++;
    if (log_addr.size() !== 1) begin
      mismatched++;
      $display("FAIL junk_nwrites: got %0d expected 1", log_addr.size());
    end else if ({log_addr[0], log_data[0], log_be[0]} !== {15'h0020, 32'hB3B2B1B0, 4'hF}) begin
      mismatched++;
      $display("FAIL junk_data: got @%h %h be=%b expected @0020 b3b2b1b0 be=1111",
               log_addr[0], log_data[0], log_be[0]);
    end
  endtask

  task automatic test_overflow();
    int not_ready = 0;
    do_start(15'd24998);
    for (int i = 0; i < 16; i++) begin
      if (in_ready !== 1'b1) not_ready++;
      beat(8'(i + 1), i == 0, i == 15);
    end
    compared++;
    if (not_ready !== 0) begin
      mismatched++;
      $display("FAIL overflow_ready: in_ready low on %0d beats expected 0", not_ready);
    end
    wait_done();
    tick(3);
    compared++;
    if (overflow !== 1'b1 || done !== 1'b1 || word_count !== 15'd2) begin
      mismatched++;
      $display("FAIL overflow_status: ovf=%b done=%b count=%0d expected 1 1 2", overflow, done, word_count);
    end
    compared++;
    if (log_addr.size() !== 2) begin
      mismatched++;
      $display("FAIL overflow_nwrites: got %0d expected 2", log_addr.size());
    end else if ({log_addr[0], log_data[0], log_addr[1], log_data[1]} !==
                 {15'd24998, 32'h04030201, 15'd24999, 32'h08070605}) begin
      mismatched++;
      $display("FAIL overflow_data: got @%0d %h, @%0d %h expected @24998 04030201, @24999 08070605",
               log_addr[0], log_data[0], log_addr[1], log_data[1]);
    end
  endtask

  task automatic test_framing();
    do_start(15'h0030);
    compared++;
    if (overflow !== 1'b0 || done !== 1'b0 || word_count !== 15'd0) begin
      mismatched++;
      $display("FAIL start_clears: ovf=%b done=%b count=%0d expected 0 0 0", overflow, done, word_count);
    end
    for (int i = 0; i < 5; i++) beat(8'h11 + 8'(i), i == 0, 1'b0);
    beat(8'h99, 1'b1, 1'b0);
    wait_done();
    tick(3);
    compared++;
    if (framing_err !== 1'b1 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL framing_status: ferr=%b done=%b expected 1 1", framing_err, done);
    end
    compared++;
    if (log_addr.size() !== 2) begin
      mismatched++;
      $display("FAIL framing_nwrites: got %0d expected 2", log_addr.size());
    end else if ({log_addr[0], log_data[0], log_be[0], log_addr[1], log_data[1], log_be[1]} !==
                 {15'h0030, 32'h14131211, 4'hF, 15'h0031, 32'h00000015, 4'b0001}) begin
      mismatched++;
      $display("FAIL framing_data: got @%h %h %b, @%h %h %b expected @0030 14131211 1111, @0031 00000015 0001",
               log_addr[0], log_data[0], log_be[0], log_addr[1], log_data[1], log_be[1]);
    end
  endtask

  task automatic test_single();
    do_start(15'h0040);
    beat(8'h5A, 1'b1, 1'b1);
    compared++;
    if ({busy, in_ready, done, mem_write, mem_chipselect} !== 5'b10011) begin
      mismatched++;
      $display("FAIL single_flush_cycle: busy/ready/done/wr/cs got %b expected 10011",
               {busy, in_ready, done, mem_write, mem_chipselect});
    end
    wait_done();
    tick(3);
    compared++;
    if (log_addr.size() !== 1) begin
      mismatched++;
      $display("FAIL single_nwrites: got %0d expected 1", log_addr.size());
    end else if ({log_addr[0], log_data[0], log_be[0]} !== {15'h0040, 32'h0000005A, 4'b0001}) begin
      mismatched++;
      $display("FAIL single_data: got @%h %h be=%b expected @0040 0000005a be=0001",
               log_addr[0], log_data[0], log_be[0]);
    end
  endtask

  task automatic test_start_ignored();
    do_start(15'h0050);
    beat(8'hD0, 1'b1, 1'b0);
    start = 1'b1; base_addr = 15'h0070;
    tick();
    start = 1'b0;
    beat(8'hD1, 1'b0, 1'b0);
    beat(8'hD2, 1'b0, 1'b0);
    beat(8'hD3, 1'b0, 1'b1);
    wait_done();
    tick(3);
    compared++;
    if (log_addr.size() !== 1) begin
      mismatched++;
      $display("FAIL start_ignored_nwrites: got %0d expected 1", log_addr.size());
    end else if ({log_addr[0], log_data[0]} !== {15'h0050, 32'hD3D2D1D0}) begin
      mismatched++;
      $display("FAIL start_ignored_data: got @%h %h expected @0050 d3d2d1d0", log_addr[0], log_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_start(15'h0060);
    for (int i = 0; i < 4; i++) beat(8'hE0 + 8'(i), i == 0, 1'b0);
    compared++;
    if (mem_write !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_pre_write: mem_write got %b expected 1", mem_write);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({mem_write, mem_chipselect, mem_clken, busy, in_ready, word_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_async: wr/cs/clken/busy/ready=%b count=%0d expected all zero",
               {mem_write, mem_chipselect, mem_clken, busy, in_ready}, word_count);
    end
    tick(2);
    reset = 1'b0;
    log_addr.delete(); log_data.delete(); log_be.delete();
    in_data = 8'hEE; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    tick(4);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    tick(2);
    compared++;
    if (log_addr.size() !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_quiet: writes=%0d busy=%b expected 0 0", log_addr.size(), busy);
    end
    do_start(15'h0061);
    beat(8'hC1, 1'b1, 1'b1);
    wait_done();
    tick(3);
    compared++;
    if (log_addr.size() !== 1) begin
      mismatched++;
      $display("FAIL reset_mid_recover_nwrites: got %0d expected 1", log_addr.size());
    end else if ({log_addr[0], log_data[0], log_be[0]} !== {15'h0061, 32'h000000C1, 4'b0001}) begin
      mismatched++;
      $display("FAIL reset_mid_recover_data: got @%h %h be=%b expected @0061 000000c1 be=0001",
               log_addr[0], log_data[0], log_be[0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_junk();
    test_overflow();
    test_framing();
    test_single();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
